// File: rtl/exec_sequencer_if.sv
// Bus handshake bundle between the exec sequencer and the fetch / data-memory bus interface.
// The sequencer is the master: it raises requests and consumes grants and completions.
interface exec_sequencer_if;
    logic ifetch_req;
    logic ifetch_gnt;
    logic ifetch_rvalid;
    logic dmem_req;
    logic dmem_we;
    logic dmem_gnt;
    logic dmem_done;

    modport master (
        output ifetch_req,
        output dmem_req,
        output dmem_we,
        input  ifetch_gnt,
        input  ifetch_rvalid,
        input  dmem_gnt,
        input  dmem_done
    );

    modport slave (
        input  ifetch_req,
        input  dmem_req,
        input  dmem_we,
        output ifetch_gnt,
        output ifetch_rvalid,
        output dmem_gnt,
        output dmem_done
    );
endinterface

// File: rtl/exec_sequencer.sv
// Multi-cycle control FSM for the copperv core: fetch, decode, execute, memory, writeback.
// inst_type encoding: 0 lui, 1 int_imm, 2 int_reg, 3 branch, 4 jal, 5 jalr, 6 load, 7 store, 8 auipc, 9 fence.
module exec_sequencer #(
    parameter int inst_type_width = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [inst_type_width-1:0] inst_type,
    input  logic                       alu_comp,
    exec_sequencer_if.master           bus,
    output logic                       ir_load,
    output logic                       alu_a_sel,
    output logic                       alu_b_sel,
    output logic [1:0]                 rd_sel,
    output logic                       rf_we,
    output logic [1:0]                 pc_sel,
    output logic                       pc_en,
    output logic [2:0]                 state
);

    localparam logic [inst_type_width-1:0] IT_IMM     = inst_type_width'(0);
    localparam logic [inst_type_width-1:0] IT_INT_IMM = inst_type_width'(1);
    localparam logic [inst_type_width-1:0] IT_INT_REG = inst_type_width'(2);
    localparam logic [inst_type_width-1:0] IT_BRANCH  = inst_type_width'(3);
    localparam logic [inst_type_width-1:0] IT_JAL     = inst_type_width'(4);
    localparam logic [inst_type_width-1:0] IT_JALR    = inst_type_width'(5);
    localparam logic [inst_type_width-1:0] IT_LOAD    = inst_type_width'(6);
    localparam logic [inst_type_width-1:0] IT_STORE   = inst_type_width'(7);
    localparam logic [inst_type_width-1:0] IT_AUIPC   = inst_type_width'(8);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_INST = 3'd2,
        S_DECODE    = 3'd3,
        S_EXEC      = 3'd4,
        S_MEM_REQ   = 3'd5,
        S_MEM_WAIT  = 3'd6,
        S_WB        = 3'd7
    } state_t;

    state_t                     state_q, state_d;
    logic [inst_type_width-1:0] type_q;
    logic                       taken_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            type_q  <= '0;
            taken_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) type_q  <= inst_type;
            if (state_q == S_EXEC)   taken_q <= alu_comp;
        end
    end

    assign state = state_q;

    always_comb begin
        state_d        = state_q;
        bus.ifetch_req = 1'b0;
        bus.dmem_req   = 1'b0;
        bus.dmem_we    = 1'b0;
        ir_load        = 1'b0;
        alu_a_sel      = 1'b0;
        alu_b_sel      = 1'b0;
        rd_sel         = 2'd0;
        rf_we          = 1'b0;
        pc_sel         = 2'd0;
        pc_en          = 1'b0;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                bus.ifetch_req = 1'b1;
                if (bus.ifetch_gnt && bus.ifetch_rvalid) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end else if (bus.ifetch_gnt) begin
                    state_d = S_WAIT_INST;
                end
            end
            S_WAIT_INST: begin
                if (bus.ifetch_rvalid) begin
                    ir_load = 1'b1;
                    state_d = S_DECODE;
                end
            end
            S_DECODE: state_d = S_EXEC;
            S_EXEC: begin
                case (type_q)
                    IT_INT_IMM:        alu_b_sel = 1'b1;
                    IT_AUIPC: begin
                        alu_a_sel = 1'b1;
                        alu_b_sel = 1'b1;
                    end
                    IT_LOAD, IT_STORE: alu_b_sel = 1'b1;
                    default: ;
                endcase
                state_d = (type_q == IT_LOAD || type_q == IT_STORE) ? S_MEM_REQ : S_WB;
            end
            S_MEM_REQ: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we  = (type_q == IT_STORE);
                if (bus.dmem_gnt && bus.dmem_done) state_d = S_WB;
                else if (bus.dmem_gnt)             state_d = S_MEM_WAIT;
            end
            S_MEM_WAIT: begin
                if (bus.dmem_done) state_d = S_WB;
            end
            S_WB: begin
                pc_en   = 1'b1;
                state_d = S_FETCH;
                // Unlisted classes (store, fence, unused codes) fall through as a plain pc+4.
                case (type_q)
                    IT_INT_REG, IT_INT_IMM, IT_AUIPC: rf_we = 1'b1;
                    IT_LOAD: begin
                        rf_we  = 1'b1;
                        rd_sel = 2'd1;
                    end
                    IT_IMM: begin
                        rf_we  = 1'b1;
                        rd_sel = 2'd3;
                    end
                    IT_JAL: begin
                        rf_we  = 1'b1;
                        rd_sel = 2'd2;
                        pc_sel = 2'd1;
                    end
                    IT_JALR: begin
                        rf_we  = 1'b1;
                        rd_sel = 2'd2;
                        pc_sel = 2'd2;
                    end
                    IT_BRANCH: pc_sel = {1'b0, taken_q};
                    default: ;
                endcase
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule
